// File: rtl/fc_layer.sv
// Fully connected layer: streams NUM_INPUTS pooled elements, accumulates one signed sum per neuron.
// Define FC_ARGMAX_EN to add the ARGMAX scan that drives out_class; otherwise out_class is tied to 0.
module fc_layer #(
   parameter int NUM_INPUTS   = 40,
   parameter int NUM_OUTPUTS  = 10,
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACC_WIDTH    = 24,
   localparam int CLASS_WIDTH = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic                                start,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DATA_WIDTH-1:0]               in_data,
   input  logic [NUM_OUTPUTS*WEIGHT_WIDTH-1:0] in_weights,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [NUM_OUTPUTS*ACC_WIDTH-1:0]    out_data,
   output logic [CLASS_WIDTH-1:0]              out_class,
   output logic                                busy
);

   localparam int CNT_WIDTH  = $clog2(NUM_INPUTS + 1);
   localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCUM  = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd3;
`ifdef FC_ARGMAX_EN
   localparam logic [1:0] S_ARGMAX = 2'd2;
`endif

   logic [1:0]                  state;
   logic [1:0]                  state_next;
   logic [CNT_WIDTH-1:0]        elem_count;
   logic signed [ACC_WIDTH-1:0] acc     [NUM_OUTPUTS];
   logic signed [ACC_WIDTH-1:0] acc_sum [NUM_OUTPUTS];
   logic signed [PROD_WIDTH-1:0] prod   [NUM_OUTPUTS];
   logic                        accept;
   logic                        last_elem;

`ifdef FC_ARGMAX_EN
   logic [CLASS_WIDTH-1:0]      scan_idx;
   logic [CLASS_WIDTH-1:0]      best_idx;
   logic                        scan_gt;
   logic                        scan_last;
`endif

   assign accept    = in_valid && in_ready;
   assign last_elem = accept && (elem_count == CNT_WIDTH'(NUM_INPUTS - 1));

   // Data is unsigned, so a zero bit in front makes it a non-negative signed operand.
   always_comb begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
         prod[o]    = PROD_WIDTH'($signed({1'b0, in_data}))
                    * PROD_WIDTH'($signed(in_weights[o*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
         acc_sum[o] = acc[o] + ACC_WIDTH'(prod[o]);
      end
   end

`ifdef FC_ARGMAX_EN
   assign scan_gt   = acc[scan_idx] > acc[best_idx];
   assign scan_last = (scan_idx == CLASS_WIDTH'(NUM_OUTPUTS - 1));
`endif

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (last_elem) begin
`ifdef FC_ARGMAX_EN
               state_next = (NUM_OUTPUTS > 1) ? S_ARGMAX : S_DONE;
`else
               state_next = S_DONE;
`endif
            end
         end
`ifdef FC_ARGMAX_EN
         S_ARGMAX: begin
            if (scan_last) begin
               state_next = S_DONE;
            end
         end
`endif
         S_DONE: begin
            if (out_ready) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Handshake flags are registered copies of the next state so every output comes from a flop.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         in_ready  <= (state_next == S_ACCUM);
         busy      <= (state_next != S_IDLE);
         out_valid <= (state_next == S_DONE);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         elem_count <= '0;
         for (int o = 0; o < NUM_OUTPUTS; o++) begin
            acc[o] <= '0;
         end
      end else if (state == S_IDLE && start) begin
         elem_count <= '0;
         for (int o = 0; o < NUM_OUTPUTS; o++) begin
            acc[o] <= '0;
         end
      end else if (accept) begin
         elem_count <= elem_count + CNT_WIDTH'(1);
         for (int o = 0; o < NUM_OUTPUTS; o++) begin
            acc[o] <= acc_sum[o];
         end
      end
   end

   // A direct ACCUM->DONE hop must capture the sums including the element accepted on that edge.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         out_data <= '0;
      end else if (state != S_DONE && state_next == S_DONE) begin
         for (int o = 0; o < NUM_OUTPUTS; o++) begin
            out_data[o*ACC_WIDTH +: ACC_WIDTH] <= (state == S_ACCUM) ? acc_sum[o] : acc[o];
         end
      end
   end

`ifdef FC_ARGMAX_EN
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         scan_idx  <= '0;
         best_idx  <= '0;
         out_class <= '0;
      end else if (state == S_ACCUM && state_next == S_ARGMAX) begin
         scan_idx <= CLASS_WIDTH'(1);
         best_idx <= '0;
      end else if (state == S_ARGMAX) begin
         scan_idx <= scan_idx + CLASS_WIDTH'(1);
         if (scan_gt) begin
            best_idx <= scan_idx;
         end
         if (scan_last) begin
            out_class <= scan_gt ? scan_idx : best_idx;
         end
      end
   end
`else
   assign out_class = '0;
`endif

endmodule

// File: tb/tb_fc_layer.sv
// Self-checking bench for fc_layer (4 inputs, 3 neurons, 16-bit accumulators).
// Expectations adapt to whether FC_ARGMAX_EN is defined for the build.
module tb_fc_layer;

   localparam int NI = 4;
   localparam int NO = 3;
   localparam int DW = 8;
   localparam int WW = 8;
   localparam int AW = 16;
`ifdef FC_ARGMAX_EN
   localparam bit ARGMAX_ON = 1'b1;
`else
   localparam bit ARGMAX_ON = 1'b0;
`endif
   localparam int GAP       = ARGMAX_ON ? NO - 1 : 0;
   localparam int CLS_BASIC = ARGMAX_ON ? 2 : 0;

   logic              clock;
   logic              reset_n;
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_data;
   logic [NO*WW-1:0]  in_weights;
   logic              out_valid;
   logic              out_ready;
   logic [NO*AW-1:0]  out_data;
   logic [1:0]        out_class;
   logic              busy;

   int checks   = 0;
   int failures = 0;
   bit compare_on = 1'b0;

   fc_layer #(
      .NUM_INPUTS  (NI),
      .NUM_OUTPUTS (NO),
      .DATA_WIDTH  (DW),
      .WEIGHT_WIDTH(WW),
      .ACC_WIDTH   (AW)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_weights(in_weights),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_class (out_class),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkVal(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint outAt(input int o);
      logic [AW-1:0] s;
      s = out_data[o*AW +: AW];
      return longint'($signed(s));
   endfunction

   function automatic logic [NO*WW-1:0] packW(input int w0, input int w1, input int w2);
      logic [WW-1:0] a, b, c;
      a = WW'(w0);
      b = WW'(w1);
      c = WW'(w2);
      return {c, b, a};
   endfunction

   // Reference model: phase 0 idle, 1 accumulating, 2 argmax scan, 3 results held.
   int     m_phase = 0;
   int     m_count = 0;
   int     m_wait  = 0;
   longint m_sum [NO];
   longint m_res [NO];
   int     m_cls = 0;
   longint exp_data [NO];
   int     exp_class = 0;

   initial begin
      for (int o = 0; o < NO; o++) begin
         m_sum[o] = 0; m_res[o] = 0; exp_data[o] = 0;
      end
   end

   task automatic finishFrame();
      logic [AW-1:0] lo;
      for (int o = 0; o < NO; o++) begin
         lo = m_sum[o][AW-1:0];
         m_res[o] = longint'($signed(lo));
      end
      m_cls = 0;
      for (int o = 1; o < NO; o++) begin
         if (m_res[o] > m_res[m_cls]) m_cls = o;
      end
      if (ARGMAX_ON) begin
         m_phase = 2;
         m_wait  = NO - 1;
      end else begin
         m_phase = 3;
         for (int o = 0; o < NO; o++) exp_data[o] = m_res[o];
         exp_class = 0;
      end
   endtask

   always @(posedge clock) begin
      if (!reset_n) begin
         m_phase = 0;
         m_count = 0;
         for (int o = 0; o < NO; o++) begin
            m_sum[o] = 0; exp_data[o] = 0;
         end
         exp_class = 0;
      end else begin
         case (m_phase)
            0: if (start) begin
                  m_phase = 1;
                  m_count = 0;
                  for (int o = 0; o < NO; o++) m_sum[o] = 0;
               end
            1: if (in_valid) begin
                  for (int o = 0; o < NO; o++)
                     m_sum[o] += longint'(in_data) * longint'($signed(in_weights[o*WW +: WW]));
                  m_count++;
                  if (m_count == NI) finishFrame();
               end
            2: begin
                  m_wait--;
                  if (m_wait == 0) begin
                     m_phase = 3;
                     for (int o = 0; o < NO; o++) exp_data[o] = m_res[o];
                     exp_class = m_cls;
                  end
               end
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clock) begin
      if (compare_on) begin
         checkVal("cmp_in_ready", in_ready, (m_phase == 1) ? 1 : 0);
         checkVal("cmp_busy", busy, (m_phase != 0) ? 1 : 0);
         checkVal("cmp_out_valid", out_valid, (m_phase == 3) ? 1 : 0);
         if (m_phase != 2) begin
            for (int o = 0; o < NO; o++) checkVal($sformatf("cmp_out_data%0d", o), outAt(o), exp_data[o]);
            checkVal("cmp_out_class", out_class, exp_class);
         end
      end
   end

   task automatic applyStimulus(input int d, input logic [NO*WW-1:0] w);
      int n;
      in_data    = DW'(d);
      in_weights = w;
      in_valid   = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      checkVal("accept_timeout", (n >= 50) ? 1 : 0, 0);
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic startFrame();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic waitResult(input int exp_gap);
      int k;
      k = 0;
      while (!out_valid && k < 50) begin
         @(posedge clock); #1;
         k++;
      end
      checkVal("latency", k, exp_gap);
   endtask

   task automatic checkOutput(input int e0, input int e1, input int e2, input int ecls);
      checkVal("lit_out_valid", out_valid, 1);
      checkVal("lit_data0", outAt(0), e0);
      checkVal("lit_data1", outAt(1), e1);
      checkVal("lit_data2", outAt(2), e2);
      checkVal("lit_class", out_class, ecls);
   endtask

   task automatic checkCleared(input string tag);
      checkVal({tag, "_out_valid"}, out_valid, 0);
      checkVal({tag, "_busy"}, busy, 0);
      checkVal({tag, "_in_ready"}, in_ready, 0);
      checkVal({tag, "_data"}, longint'(out_data), 0);
      checkVal({tag, "_class"}, out_class, 0);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [NO*AW-1:0] held;
      reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
      in_weights = '0; out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      compare_on = 1'b1;
      checkCleared("reset");
      reset_n = 1'b1;

      $display("[TB] basic frame");
      startFrame();
      for (int d = 1; d <= 4; d++) applyStimulus(d, packW(1, -1, 2));
      waitResult(GAP);
      checkOutput(10, -10, 20, CLS_BASIC);
      consume();

      $display("[TB] backpressure");
      startFrame();
      applyStimulus(1, packW(1, -1, 2));
      applyStimulus(2, packW(1, -1, 2));
      repeat (3) begin @(posedge clock); #1; end
      applyStimulus(3, packW(1, -1, 2));
      applyStimulus(4, packW(1, -1, 2));
      waitResult(GAP);
      held = out_data;
      repeat (5) begin
         @(posedge clock); #1;
         checkVal("hold_data", longint'(out_data), longint'(held));
         checkVal("hold_in_ready", in_ready, 0);
      end
      checkOutput(10, -10, 20, CLS_BASIC);
      consume();

      $display("[TB] ties");
      startFrame();
      for (int i = 0; i < NI; i++) applyStimulus(0, packW(5, -3, 7));
      waitResult(GAP);
      checkOutput(0, 0, 0, 0);
      consume();

      $display("[TB] wrap");
      startFrame();
      for (int i = 0; i < NI; i++) applyStimulus(255, packW(127, 127, 127));
      waitResult(GAP);
      checkOutput(-1532, -1532, -1532, 0);
      consume();

      $display("[TB] reset mid-frame");
      startFrame();
      applyStimulus(1, packW(3, 4, 5));
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      checkVal("start_ignored_in_ready", in_ready, 1);
      applyStimulus(1, packW(3, 4, 5));
      reset_n = 1'b0;
      @(posedge clock); #1;
      checkCleared("midreset");
      reset_n = 1'b1;
      startFrame();
      for (int i = 0; i < NI; i++) applyStimulus(1, packW(1, 1, 1));
      waitResult(GAP);
      checkOutput(4, 4, 4, 0);

      $display("[TB] start on handshake edge");
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      checkVal("hs_busy", busy, 0);
      @(posedge clock); #1;
      start = 1'b0;
      checkVal("hs_new_in_ready", in_ready, 1);
      for (int i = 0; i < NI; i++) applyStimulus(2, packW(1, 0, -1));
      waitResult(GAP);
      checkOutput(8, 0, -8, 0);
      consume();

      repeat (2) @(posedge clock);
      #1;
      compare_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
